// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared types for the core bus arbiter: ibus/dbus/cbus request and response
// payloads, the access-size encoding, the arbiter FSM state and a helper that
// picks the 32-bit instruction lane from a 64-bit bus beat.
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    localparam int unsigned CORE_ADDR_W  = 64;
    localparam int unsigned CORE_DATA_W  = 64;
    localparam int unsigned CORE_STRB_W  = 8;
    localparam int unsigned CORE_INSTR_W = 32;

    // Access size in bytes: 1, 2, 4, 8
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                   valid;
        logic [CORE_ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic                    addr_ok;
        logic                    data_ok;
        logic [CORE_INSTR_W-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic                   valid;
        logic [CORE_ADDR_W-1:0] addr;
        msize_t                 size;
        logic [CORE_STRB_W-1:0] strobe;
        logic [CORE_DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic                   addr_ok;
        logic                   data_ok;
        logic [CORE_DATA_W-1:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [CORE_ADDR_W-1:0] addr;
        msize_t                 size;
        logic [CORE_STRB_W-1:0] strobe;
        logic [CORE_DATA_W-1:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic [CORE_DATA_W-1:0] data;
    } cbus_resp_t;

    // Select the instruction word inside a 64-bit beat by address bit 2
    function automatic logic [CORE_INSTR_W-1:0] ibus_lane(
        input logic [CORE_DATA_W-1:0] beat,
        input logic                   hi
    );
        return hi ? beat[CORE_DATA_W-1 -: CORE_INSTR_W] : beat[CORE_INSTR_W-1:0];
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Bundles the core-side ibus/dbus ports and the shared cbus port.
//   slave  : arbiter view (takes ireq/dreq/oresp, drives iresp/dresp/oreq)
//   master : environment view (core + memory side)
// -----------------------------------------------------------------------------
interface bus_arbiter_if;
    import bus_arbiter_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    modport slave (
        input  ireq, dreq, oresp,
        output iresp, dresp, oreq
    );

    modport master (
        output ireq, dreq, oresp,
        input  iresp, dresp, oreq
    );
endinterface

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-to-one arbiter merging the instruction bus and data bus onto one cbus.
// The winning request is latched on grant and drives oreq until the memory
// side returns ready; the owner then gets a one-cycle addr_ok/data_ok pulse.
// Ties alternate so neither requestor starves.
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-low
//   arb    : bus_arbiter_if.slave (ireq/dreq/oresp in, iresp/dresp/oreq out)
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter bit          DATA_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave arb
);

    arb_state_t        r_state;
    cbus_req_t         r_oreq;
    logic              r_yield;   // default-priority side gives up the next tie

    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_done;
    logic [DATA_W-1:0] w_rdata;

    // dbus wins when alone, or on a tie when the (possibly flipped) priority favours it
    assign w_grant_d = arb.dreq.valid & (~arb.ireq.valid | (DATA_FIRST ^ r_yield));
    assign w_grant_i = arb.ireq.valid & ~w_grant_d;
    assign w_done    = (r_state != IDLE) & arb.oresp.ready;
    assign w_rdata   = DATA_W'(arb.oresp.data);

    // Bus request only ever comes from the holding register
    assign arb.oreq = r_oreq;

    // FSM plus holding register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_oreq  <= '0;
            r_yield <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state         <= DBUSY;
                        r_oreq.valid    <= 1'b1;
                        r_oreq.is_write <= |arb.dreq.strobe;
                        r_oreq.addr     <= CORE_ADDR_W'(arb.dreq.addr[ADDR_W-1:0]);
                        r_oreq.size     <= arb.dreq.size;
                        r_oreq.strobe   <= arb.dreq.strobe;
                        r_oreq.data     <= CORE_DATA_W'(arb.dreq.data[DATA_W-1:0]);
                    end else if (w_grant_i) begin
                        r_state         <= IBUSY;
                        r_oreq.valid    <= 1'b1;
                        r_oreq.is_write <= 1'b0;
                        r_oreq.addr     <= CORE_ADDR_W'(arb.ireq.addr[ADDR_W-1:0]);
                        r_oreq.size     <= MSIZE4;
                        r_oreq.strobe   <= '0;
                        r_oreq.data     <= '0;
                    end
                end
                IBUSY, DBUSY: begin
                    if (arb.oresp.ready) begin
                        r_state <= IDLE;
                        r_oreq  <= '0;
                        // Completing on the default side flips the next tie once
                        r_yield <= ((r_state == DBUSY) == DATA_FIRST);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_oreq  <= '0;
                end
            endcase
        end
    end

    // Response muxing: only the owner sees the completion pulse
    always_comb begin
        arb.iresp = '0;
        arb.dresp = '0;
        if (w_done) begin
            if (r_state == IBUSY) begin
                arb.iresp.addr_ok = 1'b1;
                arb.iresp.data_ok = 1'b1;
                arb.iresp.data    = ibus_lane(CORE_DATA_W'(w_rdata), r_oreq.addr[2]);
            end else begin
                arb.dresp.addr_ok = 1'b1;
                arb.dresp.data_ok = 1'b1;
                arb.dresp.data    = CORE_DATA_W'(w_rdata);
            end
        end
    end

endmodule
